mux_pipe_n: RTL and testbench

- Parametrised N:1 word multiplexer with a registered output and a valid/ready handshake on both sides.
- Successor to the fixed 8-input, 32-bit combinational mux.
- Adds generic width and input count, defined out-of-range select handling, and an auto-scan (round-robin) select mode.
- Adds a 2-entry skid buffer, so the block sits between register-file/forwarding sources and a stalling pipeline stage without combinational ready paths.

---
 rtl/mux_pipe_n.sv | 75 +++++++
 tb/tb_mux_pipe_n.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N:1 word mux with registered output, 2-entry skid buffer and round-robin select mode
module mux_pipe_n #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        mode_rr,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_err,
    output logic                        out_valid,
    input  logic                        out_ready
);
    logic [SEL_W-1:0] ptr, idx, skid_sel;
    logic [WIDTH-1:0] word, skid_data;
    logic             err, skid_err, skid_valid, acc, drain;
    assign in_ready = !skid_valid;
    assign acc      = in_valid && in_ready;
    assign drain    = !out_valid || out_ready;
    assign idx      = mode_rr ? ptr : sel;
    assign err      = 32'(idx) >= NUM_INPUTS;
    // select the addressed word; an out-of-range index matches nothing and yields 0
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (idx == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
    end
    // round-robin pointer advances only on accepts made in round-robin mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (acc && mode_rr) ptr <= (32'(ptr) == NUM_INPUTS - 1) ? '0 : ptr + SEL_W'(1);
    end
    // output register: loads from the skid entry first so order is preserved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
        end else if (drain) begin
            out_valid <= skid_valid || acc;
            if (skid_valid) begin
                out_data <= skid_data;
                out_sel  <= skid_sel;
                out_err  <= skid_err;
            end else if (acc) begin
                out_data <= word;
                out_sel  <= idx;
                out_err  <= err;
            end
        end
    end
    // skid entry: catches an accept while the output is stalled, empties when the output drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_err   <= 1'b0;
        end else if (drain) begin
            skid_valid <= 1'b0;
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= word;
            skid_sel   <= idx;
            skid_err   <= err;
        end
    end
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: scoreboard bench for mux_pipe_n with directed and random traffic plus a small variant
module tb_mux_pipe_n;
    localparam int W = 32;
    localparam int N = 8;
    localparam int S = 5;
    typedef struct packed {
        logic [W-1:0] d;
        logic [S-1:0] s;
        logic         e;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    logic [N*W-1:0] in_data;
    logic [S-1:0] sel, out_sel;
    logic mode_rr, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [W-1:0] out_data;
    logic [47:0] v_in_data;
    logic [1:0] v_sel, v_out_sel;
    logic v_mode, v_in_valid, v_in_ready, v_out_valid, v_out_err;
    logic [15:0] v_out_data;
    logic [15:0] vw [3];
    exp_t q[$];
    exp_t p_e, m_e, held;
    logic held_v = 1'b0;
    int p_idx;
    int rr_m = 0;
    int vectors = 0;
    int miscompares = 0;
    logic m;
    always #5 clk = ~clk;
    mux_pipe_n #(.WIDTH(W), .NUM_INPUTS(N), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .mode_rr(mode_rr),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );
    mux_pipe_n #(.WIDTH(16), .NUM_INPUTS(3), .SEL_W(2)) dut_v (
        .clk(clk), .rst_n(rst_n), .in_data(v_in_data), .sel(v_sel), .mode_rr(v_mode),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .out_data(v_out_data), .out_sel(v_out_sel),
        .out_err(v_out_err), .out_valid(v_out_valid), .out_ready(1'b1)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [S-1:0] s, input logic md, input logic r);
        @(posedge clk);
        #1;
        in_valid = v;
        sel = s;
        mode_rr = md;
        out_ready = r;
    endtask
    // reference model: an accept happens at the next edge, predict its result from the rules
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            p_idx = mode_rr ? rr_m : int'(sel);
            p_e.s = S'(p_idx);
            p_e.e = p_idx >= N;
            p_e.d = '0;
            if (p_idx < N) p_e.d = in_data[p_idx*W +: W];
            if (mode_rr) rr_m = (rr_m + 1) % N;
            q.push_back(p_e);
        end
    end
    // monitor: compare every output transfer in order and check stability while stalled
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) chk("hold", 64'({out_valid, out_data, out_sel, out_err}), 64'({1'b1, held}));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %h expected none", {out_data, out_sel, out_err});
                end else begin
                    m_e = q.pop_front();
                    chk("out", 64'({out_data, out_sel, out_err}), 64'(m_e));
                end
            end
            held_v = out_valid && !out_ready;
            held = {out_data, out_sel, out_err};
        end
    end
    initial begin
        in_valid = 0; sel = '0; mode_rr = 0; out_ready = 0;
        v_in_valid = 0; v_sel = '0; v_mode = 0;
        v_in_data = {16'hC3C3, 16'hB2B2, 16'hA1A1};
        vw = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
        in_data = {32'h0011C03F, 32'h0000703F, 32'h0000000F, 32'h00000027,
                   32'h0000603F, 32'h0C000039, 32'h0000803F, 32'h0000003F};
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));
        chk("rst_err", 64'(out_err), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        drive(1, 7, 0, 1);
        drive(0, 0, 0, 1);
        chk("t1_data", 64'(out_data), 64'(32'h0011C03F));
        chk("t1_sel", 64'(out_sel), 64'(7));
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_err", 64'(out_err), 64'(0));
        drive(1, 9, 0, 1);
        drive(1, 2, 0, 1);
        chk("t2_err", 64'(out_err), 64'(1));
        chk("t2_data", 64'(out_data), 64'(0));
        chk("t2_sel", 64'(out_sel), 64'(9));
        drive(0, 0, 0, 1);
        chk("t2_next", 64'({out_data, out_err}), 64'({32'h0C000039, 1'b0}));
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        chk("t3_full", 64'(in_ready), 64'(0));
        drive(1, 2, 0, 0);
        chk("t3_held", 64'(in_ready), 64'(0));
        drive(1, 2, 0, 1);
        drive(1, 2, 0, 1);
        chk("t3_nogap", 64'(out_valid), 64'(1));
        drive(0, 0, 0, 1);
        chk("t3_last", 64'(out_data), 64'(32'h0C000039));
        drive(0, 0, 0, 1);
        repeat (10) drive(1, 0, 1, 1);
        drive(1, 4, 0, 1);
        drive(1, 0, 1, 1);
        chk("t4_sel4", 64'(out_sel), 64'(4));
        drive(0, 0, 0, 1);
        chk("t4_resume", 64'(out_sel), 64'(2));
        drive(1, 3, 0, 0);
        drive(1, 5, 0, 0);
        drive(0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 0;
        q.delete();
        rr_m = 0;
        #1;
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #3 rst_n = 1;
        drive(1, 0, 1, 1);
        drive(0, 0, 0, 1);
        chk("t5_rr0", 64'({out_valid, out_sel}), 64'({1'b1, 5'd0}));
        m = 0;
        repeat (600) begin
            if ($urandom % 8 == 0) m = ~m;
            drive(($urandom % 4) != 0, ($urandom % 5 == 0) ? S'($urandom_range(8, 31)) : S'($urandom_range(0, 7)),
                  m, ($urandom % 10) < 7);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
        end
        drive(0, 0, 0, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
        v_in_valid = 1; v_sel = 3; v_mode = 0;
        @(posedge clk);
        #1;
        chk("t6_err", 64'({v_out_valid, v_out_err, v_out_data, v_out_sel}), 64'({1'b1, 1'b1, 16'h0, 2'd3}));
        v_mode = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t6_rr", 64'({v_out_valid, v_out_err, v_out_sel, v_out_data}), 64'({1'b1, 1'b0, 2'(i % 3), vw[i % 3]}));
        end
        v_in_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
